// File: rtl/clock_div_pkg.sv
// Shared types and helpers for the divided-clock bank.
// Config record and channel-index width calculation.
package clock_div_pkg;

  localparam int DIV_W_DEF = 8;

  typedef struct packed {
    logic                 enable;
    logic [DIV_W_DEF-1:0] divisor;
  } div_cfg_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divided-clock channel: counter, shadow config, boundary update.
// New settings land only at the end of a low phase.
module clock_div_channel
  import clock_div_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     cfg_load,
  input  div_cfg_t cfg,
  output logic     pending,
  output logic     clock_out,
  output logic     tick,
  output logic     active
);

  localparam int W = DIV_W_DEF;

  logic [W-1:0] div_q, div_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] sh_div_q, sh_div_d;
  logic         sh_en_q, sh_en_d;
  logic         pend_q, pend_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  logic         act_q, act_d;
  logic         wrap;

  assign wrap = (cnt_q == div_q);

  always_comb begin
    div_d    = div_q;
    cnt_d    = cnt_q;
    sh_div_d = sh_div_q;
    sh_en_d  = sh_en_q;
    pend_d   = pend_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;
    act_d    = act_q;
    if (act_q) begin
      if (!wrap) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
        if (clk_q) begin
          clk_d = 1'b0;
        end else if (pend_q) begin
          // boundary with a queued change
          div_d  = sh_div_q;
          pend_d = 1'b0;
          if (sh_en_q) begin
            clk_d  = 1'b1;
            tick_d = 1'b1;
          end else begin
            act_d = 1'b0;
          end
        end else begin
          clk_d  = 1'b1;
          tick_d = 1'b1;
        end
      end
      if (cfg_load) begin
        sh_div_d = cfg.divisor;
        sh_en_d  = cfg.enable;
        pend_d   = 1'b1;
      end
    end else if (cfg_load && cfg.enable) begin
      div_d  = cfg.divisor;
      cnt_d  = '0;
      clk_d  = 1'b1;
      tick_d = 1'b1;
      act_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      cnt_q    <= '0;
      sh_div_q <= '0;
      sh_en_q  <= 1'b0;
      pend_q   <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      act_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      sh_div_q <= sh_div_d;
      sh_en_q  <= sh_en_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      act_q    <= act_d;
    end
  end

  assign pending   = pend_q;
  assign clock_out = clk_q;
  assign tick      = tick_q;
  assign active    = act_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independently programmable, glitch-free divided clocks.
// One valid/ready config port; ready drops only for a busy channel.
module clock_divider_bank
  import clock_div_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int DIV_W    = DIV_W_DEF,
  parameter int CH_W     = ch_width(CHANNELS)
) (
  input  logic                core_clock,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_channel,
  input  logic [DIV_W-1:0]    cfg_divisor,
  input  logic                cfg_enable,
  output logic [CHANNELS-1:0] clock_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] active
);

  logic [CHANNELS-1:0] pend;
  div_cfg_t            cfg;
  logic                acc;

  assign cfg.enable  = cfg_enable;
  assign cfg.divisor = DIV_W_DEF'(cfg_divisor);
  assign acc         = cfg_valid & cfg_ready;

  // out-of-range channels stay ready and swallow the write
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_channel == CH_W'(i)) cfg_ready = ~pend[i];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clock_div_channel u_ch (
      .clk       (core_clock),
      .reset     (reset),
      .cfg_load  (acc && (cfg_channel == CH_W'(g))),
      .cfg       (cfg),
      .pending   (pend[g]),
      .clock_out (clock_out[g]),
      .tick      (tick[g]),
      .active    (active[g])
    );
  end

endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Parametrised clock generator that produces `CHANNELS` independently programmable divided clocks from `core_clock`. Each channel has its own divisor and enable, and reconfiguration is glitch-free: a new setting takes effect only at a period boundary. The block sits where the single-select core/io mux sat and drives per-subsystem clocks to the motor-control PWM and timing logic. A single config port with a valid/ready handshake writes the settings.

## Interface
- `CHANNELS`, default 3: number of output clocks (≥1).
- `DIV_W`, default 8: divisor width. Half-period length is `divisor+1` core cycles.
- `CH_W`, default `$clog2(CHANNELS)` (min 1): channel index width. Derived; do not override.

Ports:
- `core_clock` in 1: the only clock. All state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cfg_valid` in 1: config request.
- `cfg_ready` out 1: combinational; request accepted when `cfg_valid & cfg_ready`.
- `cfg_channel` in `CH_W`: target channel.
- `cfg_divisor` in `DIV_W`: half-period minus one.
- `cfg_enable` in 1: 1 = run, 0 = stop.
- `clock_out` out `CHANNELS`: registered divided clocks.
- `tick` out `CHANNELS`: one-cycle pulse, high in the first cycle of each high phase.
- `active` out `CHANNELS`: channel running.

## Operation
- Per channel state:
  - `div` (DIV_W), `cnt` (DIV_W), `clock_out`, `active`.
  - Shadow `sh_div`, `sh_en`, and a `pending` flag.
- Reset: every register is 0, so `clock_out`, `tick`, `active` and `pending` are all 0. `cfg_ready` is 1 after reset.
- Running channel, on each edge:
  - If `cnt != div`: `cnt+1`.
  - Else `cnt <= 0` and `clock_out` toggles.
  - Result: period = `2*(div+1)` cycles, 50% duty. `div = 0` gives `core_clock/2`; `div = 2^DIV_W-1` gives the maximum period.
- Boundary: the edge where `cnt == div` and `clock_out == 0`, i.e. the end of the low phase.
- Acceptance to an idle channel (`active = 0`):
  - `cfg_enable = 1`: load `div`, `cnt <= 0`, `clock_out <= 1`, `active <= 1`, `tick <= 1`. This all happens on the acceptance edge.
  - `cfg_enable = 0`: no effect.
- Acceptance to an active channel: capture into the shadow registers and set `pending`.
- At a boundary with `pending`:
  - `div <= sh_div`, `cnt <= 0`, `pending <= 0`.
  - If `sh_en`: `clock_out <= 1`, `tick <= 1`.
  - Else: `clock_out` stays 0 and `active <= 0`.
- At a boundary without `pending`: normal toggle to high, with `tick <= 1`.
- `cfg_ready = ~pending[cfg_channel]`. Other channels' pending state never blocks.
- `cfg_channel >= CHANNELS`: `cfg_ready = 1`; the request is accepted and discarded.
- A disabled channel always completes its current full period. No runt pulse is ever produced.
- Channels are fully independent. Simultaneous boundaries on several channels plus an acceptance on one are all honoured in the same edge.

## Timing
- Idle-channel start: `clock_out` and `tick` are high in the cycle after the acceptance edge. Latency is 1.
- Active-channel change: takes effect at the next boundary. Worst case is `2*(div_old+1)` cycles after acceptance.
- `cfg_ready` deasserts in the cycle after acceptance to an active channel. It reasserts in the cycle after that channel's boundary.
- Acceptance in the same cycle as that channel's boundary:
  - The boundary uses the old `pending`/shadow state (empty), so the channel runs a normal period.
  - The new request becomes `pending` and is applied at the following boundary.
- `reset` asserted mid-period: all outputs are 0 on the next edge. A truncated high phase on `reset` is permitted.
- `tick` is registered and coincident with the rising edge of `clock_out`.

## Structure
- Package `clock_div_pkg`:
  - `CH_W` computation function.
  - Typedef `div_cfg_t` = {`enable`, `divisor`}.
- Sub-module `clock_div_channel`: one channel's counter, shadow and boundary logic, with ports `cfg_load`, `cfg`, `pending`, `clock_out`, `tick`, `active`.
- Top level contains:
  - A `generate` loop over `CHANNELS`.
  - Channel decode and the `cfg_ready` mux.

## Test plan
- Reset, then write ch0 `div=0` enable.
  - Required: `clock_out[0]` toggles every cycle.
  - Required: `tick[0]` high every 2nd cycle, starting 1 cycle after acceptance.
- Write ch1 `div=3`, enable.
  - Required: period 8 (4 high, 4 low).
  - Required: ch0 and ch2 unaffected.
- While ch1 runs `div=3`, write `div=1` mid high-phase.
  - Required: `cfg_ready` is 0 for `cfg_channel=1` and 1 for `cfg_channel=0`.
  - Required: the old period completes, then period 4; no pulse shorter than 2 cycles.
- Disable ch1 mid-period.
  - Required: the period completes; `clock_out[1]` stays 0.
  - Required: `active[1]` falls at the boundary and `tick[1]` stops.
- Write arriving exactly at a boundary cycle.
  - Required: one more old-setting period, then the new setting.
- Write to channel 3 with `CHANNELS=3`.
  - Required: accepted with no state change.
- Assert `reset` mid-run.
  - Required: all outputs 0 the next cycle and `cfg_ready=1`.
